// File: rtl/reset_seq_pkg.sv
// Shared types and parameter helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  function automatic int idx_width(input int n_domains);
    return (n_domains > 1) ? $clog2(n_domains) : 1;
  endfunction

  function automatic bit cnt_w_ok(input int cnt_w, input int hold, input int filt);
    int longest;
    longest = (hold > filt) ? hold : filt;
    return (longest - 1) < (1 << cnt_w);
  endfunction

  function automatic bit params_ok(input int n_domains, input int hold,
                                   input int filt, input int cnt_w);
    return (n_domains >= 1) && (hold >= 2) && (filt >= 1) && cnt_w_ok(cnt_w, hold, filt);
  endfunction

endpackage

// File: rtl/sync_1bit.sv
// Two-flop synchroniser for a single asynchronous level, cleared by a synchronous reset.
module sync_1bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Holds N active-low domain resets until PLL lock is stable, then releases them
// in index order with a fixed gap; lock loss or a soft request restarts the sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int LOCK_FILTER = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic                 soft_rst_req,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 all_released,
  output logic                 seq_busy
);

  localparam int IDX_W = idx_width(N_DOMAINS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);

  if (!params_ok(N_DOMAINS, HOLD_CYCLES, LOCK_FILTER, CNT_W)) begin : g_param_err
    $error("reset_sequencer: illegal parameter combination");
  end

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                 all_rel_q, all_rel_d;
  logic                 lock_s;
  logic                 abort;

  sync_1bit u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  assign abort = !lock_s || soft_rst_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    unique case (state_q)
      ST_ASSERT: begin
        rst_n_d = '0;
        if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (soft_rst_req) begin
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end else if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_LAST) begin
          cnt_d      = '0;
          rst_n_d[0] = 1'b1;
          if (N_DOMAINS == 1) begin
            state_d = ST_RUN;
          end else begin
            idx_d   = IDX_FIRST;
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        // Abort wins over a release landing in the same cycle.
        if (abort) begin
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          state_d = ST_ASSERT;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d          = '0;
          rst_n_d[idx_q] = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          state_d = ST_ASSERT;
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
    all_rel_d = &rst_n_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_n_q   <= '0;
      all_rel_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      all_rel_q <= all_rel_d;
    end
  end

  assign rst_n_out    = rst_n_q;
  assign all_released = all_rel_q;
  assign seq_busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing scenarios plus randomized traffic,
// all checked against a timeline model of release times.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int H  = 8;
  localparam int F  = 4;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         locked;
  logic         soft_rst_req;
  logic [N-1:0] rst_n_out;
  logic         all_released;
  logic         seq_busy;

  int checks   = 0;
  int failures = 0;

  // Model: cycle count, start of current hold, cycle bit 0 is released (-1 = none),
  // consecutive synchronised-lock cycles seen after the hold, synchroniser copy.
  int   cyc;
  int   hold_start;
  int   rel0;
  int   lock_run;
  logic m1, m2;

  reset_sequencer #(
    .N_DOMAINS   (N),
    .HOLD_CYCLES (H),
    .LOCK_FILTER (F),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .rst_n_out    (rst_n_out),
    .all_released (all_released),
    .seq_busy     (seq_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] prefix_vec(input int r);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (i < r) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int model_released();
    int r;
    if (rel0 < 0 || cyc < rel0) return 0;
    r = 1 + (cyc - rel0) / H;
    return (r > N) ? N : r;
  endfunction

  // Released-bit count c cycles after sequence start, with lock stable throughout.
  function automatic int formula_released(input int c);
    int r;
    r = 0;
    for (int k = 0; k < N; k++) if (c >= H + F + k * H) r++;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle: compare outputs against the model, advance model, clock.
  task automatic step(input logic l, input logic s, input logic r);
    int   rel;
    logic ls;
    locked       = l;
    soft_rst_req = s;
    rst          = r;
    rel = model_released();
    chk("model_rst_n_out", 32'(rst_n_out), 32'(prefix_vec(rel)));
    chk("model_all_released", 32'(all_released), 32'(rel == N));
    chk("model_seq_busy", 32'(seq_busy), 32'(rel != N));
    ls = m2;
    if (r) begin
      hold_start = cyc + 1;
      rel0       = -1;
      lock_run   = 0;
      m1         = 1'b0;
      m2         = 1'b0;
    end else begin
      if (rel > 0) begin
        if (!ls || s) begin
          hold_start = cyc + 1;
          rel0       = -1;
          lock_run   = 0;
        end
      end else if (cyc < hold_start + H) begin
        if (s) hold_start = cyc + 1;
      end else if (s) begin
        hold_start = cyc + 1;
        lock_run   = 0;
      end else if (ls) begin
        lock_run++;
        if (lock_run == F) rel0 = cyc + 1;
      end else begin
        lock_run = 0;
      end
      m2 = m1;
      m1 = l;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Sequence-start-relative checks against the closed-form release schedule.
  task automatic run_formula(input int ncyc);
    int r;
    for (int c = 0; c < ncyc; c++) begin
      r = formula_released(c);
      chk("sched_rst_n_out", 32'(rst_n_out), 32'(prefix_vec(r)));
      chk("sched_all_released", 32'(all_released), 32'(r == N));
      chk("sched_seq_busy", 32'(seq_busy), 32'(r != N));
      step(1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic lr;
    int   t;
    rst          = 1'b1;
    locked       = 1'b1;
    soft_rst_req = 1'b0;
    @(posedge clk);
    #1;
    cyc        = 0;
    hold_start = 0;
    rel0       = -1;
    lock_run   = 0;
    m1         = 1'b0;
    m2         = 1'b0;

    // Reset state, then clean power-up with lock high throughout.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("reset_rst_n_out", 32'(rst_n_out), 32'd0);
    chk("reset_all_released", 32'(all_released), 32'd0);
    chk("reset_seq_busy", 32'(seq_busy), 32'd1);
    run_formula(36);

    // Soft request in RUN: immediate clear, same spacing on the rerun.
    chk("run_before_soft", 32'(rst_n_out), 32'h7);
    step(1'b1, 1'b1, 1'b0);
    chk("soft_clear", 32'(rst_n_out), 32'd0);
    run_formula(14);

    // Lock lost with only bit 0 released (sequence cycle 14).
    for (int c = 14; c < 24; c++) begin
      if (c == 16) chk("drop_still_bit0", 32'(rst_n_out), 32'h1);
      if (c == 17) chk("drop_cleared", 32'(rst_n_out), 32'd0);
      step(1'b0, 1'b0, 1'b0);
    end
    for (int c = 0; c < 60; c++) step(1'b1, 1'b0, 1'b0);
    chk("relock_run", 32'(all_released), 32'd1);

    // One-cycle rst in RUN restarts from sequence cycle 0.
    step(1'b1, 1'b0, 1'b1);
    chk("rst_clear", 32'(rst_n_out), 32'd0);
    run_formula(32);

    // Lock low for 50 cycles after reset, then high: bit 0 exactly 6 cycles later.
    step(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 50; c++) step(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      chk("late_lock_bit0", 32'(rst_n_out[0]), 32'(j >= 6));
      step(1'b1, 1'b0, 1'b0);
    end

    // One-cycle lock glitch during WAIT_LOCK delays bit 0 by three cycles.
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < H + F + 6; c++) begin
      chk("glitch_bit0", 32'(rst_n_out[0]), 32'(c >= H + F + 3));
      step(c != H, 1'b0, 1'b0);
    end

    // Randomized lock drops, soft requests and resets.
    lr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (lr) lr = ($urandom_range(0, 99) >= 2);
      else    lr = ($urandom_range(0, 99) < 30);
      t = $urandom_range(0, 999);
      step(lr, t < 8, t >= 996);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset sequencer for FPGA top levels, generalising the single-output reset generator between the PLL and the SoC. It holds `N_DOMAINS` active-low reset outputs asserted until a filtered PLL lock is seen, then releases them one at a time in index order, with a programmable gap between releases. It re-runs the whole sequence on PLL lock loss or a soft reset request, such as from a watchdog or debug logic.

## Interface
Parameters:
- `N_DOMAINS`, 3: number of reset outputs; ≥1.
- `HOLD_CYCLES`, 8: minimum assert time, and also the gap between successive releases; ≥2.
- `LOCK_FILTER`, 4: consecutive cycles of synchronised lock required before release; ≥1.
- `CNT_W`, 8: counter width; must hold max(`HOLD_CYCLES`, `LOCK_FILTER`) − 1.

Ports:
- `clk` input 1: sequencer clock, free-running (PLL output).
- `rst` input 1: synchronous, active-high reset.
- `locked` input 1: PLL lock, asynchronous to `clk`; synchronised internally.
- `soft_rst_req` input 1: single-cycle or level request, synchronous to `clk`.
- `rst_n_out` output `N_DOMAINS`: per-domain reset, active-low, registered.
- `all_released` output 1: high when every `rst_n_out` bit is high, registered.
- `seq_busy` output 1: high in any state other than RUN.

## Operation
- `locked` passes through a 2-flop synchroniser (flops reset to 0) to give `lock_s`.
- **ASSERT** (reset state):
  - All outputs are low.
  - The counter runs 0..`HOLD_CYCLES`−1, then the block goes to WAIT_LOCK.
  - `soft_rst_req` in this state clears the counter (extends the hold).
- **WAIT_LOCK**:
  - The counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - When the count reaches `LOCK_FILTER`−1 with `lock_s`=1, the block goes to RELEASE and sets `rst_n_out[0]`.
  - `soft_rst_req` sends the block to ASSERT.
- **RELEASE**:
  - The index `idx` starts at 1. Each time the counter reaches `HOLD_CYCLES`−1, the block sets `rst_n_out[idx]` and increments `idx`.
  - When the last bit is set, the block goes to RUN.
  - If `N_DOMAINS`=1, the block goes from WAIT_LOCK directly to RUN.
- **RUN**: all outputs are high and `all_released`=1.
- **Abort**: in RELEASE or RUN, `lock_s`=0 or `soft_rst_req`=1 sends the block to ASSERT. All `rst_n_out` bits clear on the transition edge, and the counter and `idx` clear.
- **Simultaneous events**: abort has priority over a release that falls in the same cycle.
- Released bits only ever form a contiguous prefix from bit 0. Bit k high implies bits 0..k−1 are high.
- **Reset values**: state=ASSERT, `rst_n_out`=0, `all_released`=0, `seq_busy`=1, counter=0, `idx`=0, synchroniser=0.

## Timing
- Cycle 0 is the first cycle after `rst` is sampled low. With `locked` held high throughout, `lock_s`=1 from cycle 2.
- Let H=`HOLD_CYCLES` and F=`LOCK_FILTER`:
  - ASSERT occupies cycles 0..H−1.
  - WAIT_LOCK occupies cycles H..H+F−1.
  - `rst_n_out[k]` rises at cycle H+F+k·H.
  - `all_released` rises in the same cycle as `rst_n_out[N_DOMAINS−1]`.
- Lock loss: if `locked` falls before the edge at cycle t, `lock_s` falls at t+2 and all outputs are low at t+3.
- Soft request: if `soft_rst_req` is sampled high at cycle t, all outputs are low at t+1.
- `rst` asserted mid-sequence: all outputs are low on the next cycle, regardless of state.
- Lock glitch during WAIT_LOCK: the filter restarts and the release time moves later by the glitch length plus the synchroniser delay.

## Structure
- Package `reset_seq_pkg` holds the state enum (ASSERT, WAIT_LOCK, RELEASE, RUN) and parameter-check helpers.
- Sub-module `sync_1bit`: 2-flop synchroniser with synchronous active-high reset, instantiated once for `locked`.
- Counter, index and outputs live in a single always block. Next-state logic is in a separate combinational block.

## Test plan
- Locked high from reset, N=3, H=8, F=4: `rst_n_out` bits rise at cycles 12, 20, 28; `all_released`=1 at 28; `seq_busy`=0 from 28.
- Locked low for 50 cycles, then high: no release before `lock_s` has been high for 4 cycles; bit 0 rises exactly 2+4 cycles after `locked` rises.
- 1-cycle low glitch on `locked` during WAIT_LOCK: filter restarts; bit 0 release delayed by 3 cycles versus no glitch.
- `soft_rst_req` pulse in RUN at cycle t: all outputs low at t+1; full sequence repeats with the same spacing.
- `locked` drops while in RELEASE with only bit 0 released: all outputs low 3 cycles later; no further bits rise until lock has been stable again.
- `rst` asserted for 1 cycle in RUN: outputs clear next cycle; sequence restarts from cycle 0.
